// File: rtl/seven_seg_capture_if.sv
// rtl/seven_seg_capture_if.sv - segment bus and decoded-digit signals of the seven-segment receiver
interface seven_seg_capture_if;
    logic [6:0]  seg_in;
    logic        sel_in;
    logic [13:0] raw_pair;
    logic [3:0]  digit_hi;
    logic [3:0]  digit_lo;
    logic        bad_hi;
    logic        bad_lo;
    logic        pair_valid;
    logic        locked;
    logic        overrun;

    modport master (
        output seg_in, sel_in,
        input  raw_pair, digit_hi, digit_lo, bad_hi, bad_lo, pair_valid, locked, overrun
    );

    modport slave (
        input  seg_in, sel_in,
        output raw_pair, digit_hi, digit_lo, bad_hi, bad_lo, pair_valid, locked, overrun
    );
endinterface

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - two-digit multiplexed seven-segment receiver with settle, decode and lock
module seven_seg_capture #(
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT    = 50000,
    parameter int TBITS      = 16
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_capture_if.slave bus
);
    localparam int SBITS = $clog2(SETTLE_CYC) + 1;
    localparam logic [SBITS-1:0] STAB_LAST = SBITS'(SETTLE_CYC - 1);
    localparam logic [TBITS-1:0] TMO_MAX   = TBITS'(TIMEOUT);

    typedef enum logic [1:0] {SYNC, SETTLE, HOLD} state_t;

    state_t            state, state_nx;
    logic              sel_d;
    logic [6:0]        seg_d;
    logic [SBITS-1:0]  stab_cnt, stab_nx;
    logic [TBITS-1:0]  tmo_cnt, tmo_nx;
    logic              hi_seen, hi_seen_nx;
    logic              locked_r, locked_nx;
    logic              pair_valid_r, pair_valid_nx;
    logic              overrun_r, overrun_nx;
    logic              capture;
    logic              sel_edge;
    logic              timed_out;
    logic [13:0]       raw_r;
    logic [3:0]        digit_hi_r, digit_lo_r;
    logic              bad_hi_r, bad_lo_r;
    logic [4:0]        dec;

    // {bad, nibble}: anything but an exact glyph decodes as 0 with bad set
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h77:   decode = 5'h0A;
            7'h7C:   decode = 5'h0B;
            7'h39:   decode = 5'h0C;
            7'h5E:   decode = 5'h0D;
            7'h79:   decode = 5'h0E;
            7'h71:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    assign sel_edge  = bus.sel_in != sel_d;
    assign timed_out = (state != SYNC) && (tmo_cnt == TMO_MAX);
    assign dec       = decode(seg_d);

    always_comb begin
        state_nx      = state;
        stab_nx       = stab_cnt;
        tmo_nx        = tmo_cnt;
        hi_seen_nx    = hi_seen;
        locked_nx     = locked_r;
        pair_valid_nx = 1'b0;
        overrun_nx    = 1'b0;
        capture       = 1'b0;

        if (sel_edge)
            tmo_nx = '0;
        else if (state != SYNC && tmo_cnt != TMO_MAX)
            tmo_nx = tmo_cnt + 1'b1;

        case (state)
            SYNC: begin
                locked_nx = 1'b0;
                if (sel_edge) begin
                    state_nx = SETTLE;
                    stab_nx  = '0;
                end
            end
            SETTLE: begin
                // an edge beats a settle that would complete this same cycle
                if (sel_edge) begin
                    overrun_nx = 1'b1;
                    stab_nx    = '0;
                end else if (bus.seg_in != seg_d) begin
                    stab_nx = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end else begin
                    stab_nx = stab_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (sel_edge) begin
                    state_nx = SETTLE;
                    stab_nx  = '0;
                end
            end
            default: state_nx = SYNC;
        endcase

        if (capture) begin
            if (bus.sel_in) begin
                hi_seen_nx = 1'b1;
            end else if (hi_seen) begin
                pair_valid_nx = 1'b1;
                locked_nx     = 1'b1;
            end
        end

        if (timed_out) begin
            state_nx      = SYNC;
            locked_nx     = 1'b0;
            hi_seen_nx    = 1'b0;
            capture       = 1'b0;
            pair_valid_nx = 1'b0;
            overrun_nx    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SYNC;
            sel_d        <= bus.sel_in;
            seg_d        <= bus.seg_in;
            stab_cnt     <= '0;
            tmo_cnt      <= '0;
            hi_seen      <= 1'b0;
            locked_r     <= 1'b0;
            pair_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
            raw_r        <= '0;
            digit_hi_r   <= '0;
            digit_lo_r   <= '0;
            bad_hi_r     <= 1'b0;
            bad_lo_r     <= 1'b0;
        end else begin
            state        <= state_nx;
            sel_d        <= bus.sel_in;
            seg_d        <= bus.seg_in;
            stab_cnt     <= stab_nx;
            tmo_cnt      <= tmo_nx;
            hi_seen      <= hi_seen_nx;
            locked_r     <= locked_nx;
            pair_valid_r <= pair_valid_nx;
            overrun_r    <= overrun_nx;
            if (capture && bus.sel_in) begin
                raw_r[13:7] <= seg_d;
                digit_hi_r  <= dec[3:0];
                bad_hi_r    <= dec[4];
            end else if (capture) begin
                raw_r[6:0]  <= seg_d;
                digit_lo_r  <= dec[3:0];
                bad_lo_r    <= dec[4];
            end
        end
    end

    assign bus.raw_pair   = raw_r;
    assign bus.digit_hi   = digit_hi_r;
    assign bus.digit_lo   = digit_lo_r;
    assign bus.bad_hi     = bad_hi_r;
    assign bus.bad_lo     = bad_lo_r;
    assign bus.pair_valid = pair_valid_r;
    assign bus.locked     = locked_r;
    assign bus.overrun    = overrun_r;
endmodule
